// File: rtl/fir_serial_feeder.sv
// fir_serial_feeder: FIFO that meters samples into a serial FIR, one en strobe per SLOT cycles.
// Define FIR_FEED_FLUSH_EN to add the DRAIN/ZFILL flush that zero-fills the 16-tap delay line.
module fir_serial_feeder #(
    parameter int DW    = 12,
    parameter int DEPTH = 8,
    parameter int SLOT  = 8
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DW-1:0]            s_data,
    input  logic                     flush,
    output logic                     en,
    output logic [DW-1:0]            xin,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     flush_busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN
`ifdef FIR_FEED_FLUSH_EN
        , DRAIN,
        ZFILL
`endif
    } state_t;

    state_t          state, state_next;
    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [7:0]      gap;
    logic            push, data_fire, zero_fire;

`ifdef FIR_FEED_FLUSH_EN
    logic [3:0]      zcnt;
`else
    logic            flush_unused;
    assign flush_unused = flush;
`endif

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
`ifdef FIR_FEED_FLUSH_EN
            IDLE:    state_next = flush ? DRAIN : (level != '0 ? RUN : IDLE);
            RUN:     state_next = flush ? DRAIN : (level == '0 && gap == '0 ? IDLE : RUN);
            DRAIN:   state_next = (level == '0 && gap == '0) ? ZFILL : DRAIN;
            ZFILL:   state_next = (zero_fire && zcnt == 4'd15) ? IDLE : ZFILL;
`else
            IDLE:    state_next = level != '0 ? RUN : IDLE;
            RUN:     state_next = (level == '0 && gap == '0) ? IDLE : RUN;
`endif
            default: state_next = IDLE;
        endcase
    end

    // en/xin are registered, so the pop decision is made a cycle ahead of the strobe
    always_comb begin
`ifdef FIR_FEED_FLUSH_EN
        flush_busy = (state == DRAIN) || (state == ZFILL);
        data_fire  = (state != ZFILL) && level != '0 && gap == '0;
        zero_fire  = (state == ZFILL) && gap == '0;
`else
        flush_busy = 1'b0;
        data_fire  = level != '0 && gap == '0;
        zero_fire  = 1'b0;
`endif
        s_ready = rstn && (level < LW'(DEPTH)) && !flush_busy;
        push    = s_valid && s_ready;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            en     <= 1'b0;
            xin    <= '0;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            gap    <= '0;
        end else begin
            en     <= data_fire || zero_fire;
            xin    <= data_fire ? mem[rd_ptr] : (zero_fire ? '0 : xin);
            wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr <= data_fire ? rd_ptr + AW'(1) : rd_ptr;
            level  <= level + LW'(push) - LW'(data_fire);
            gap    <= (data_fire || zero_fire) ? 8'(SLOT - 1) : gap - 8'(gap != '0);
        end
    end

`ifdef FIR_FEED_FLUSH_EN
    always_ff @(posedge clk) begin
        if (!rstn)          zcnt <= '0;
        else if (zero_fire) zcnt <= zcnt + 4'd1;
    end
`endif

endmodule

// File: tb/tb_fir_serial_feeder.sv
// tb_fir_serial_feeder: directed vectors against hand-derived strobe timing for fir_serial_feeder.
module tb_fir_serial_feeder;
    localparam int DW = 12, DEPTH = 8, SLOT = 8, LW = 4;

    logic          clk = 1'b0, rstn = 1'b0, s_valid = 1'b0, flush = 1'b0;
    logic          s_ready, en, flush_busy;
    logic [DW-1:0] s_data = '0, xin;
    logic [LW-1:0] level;
    logic [DW-1:0] q[$];
    int            nvec = 0, nerr = 0;

    fir_serial_feeder #(.DW(DW), .DEPTH(DEPTH), .SLOT(SLOT)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .flush(flush), .en(en), .xin(xin), .level(level), .flush_busy(flush_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  ens, sent, rcv, mlev, acc_prev, saw_full;
        bit  exp_en;
        // reset state
        repeat (3) step;
        check("rst_en", 32'(en), 0);
        check("rst_xin", 32'(xin), 0);
        check("rst_level", 32'(level), 0);
        check("rst_ready", 32'(s_ready), 0);
        check("rst_busy", 32'(flush_busy), 0);
        rstn = 1'b1;
        repeat (6) step;
        check("idle_ready", 32'(s_ready), 1);
        // basic latency: accept in c, strobe in c+2 only
        s_valid = 1'b1;
        s_data  = 12'h123;
        check("lat_ready", 32'(s_ready), 1);
        step;
        s_valid = 1'b0;
        check("lat_en_c1", 32'(en), 0);
        check("lat_lvl_c1", 32'(level), 1);
        step;
        check("lat_en_c2", 32'(en), 1);
        check("lat_xin", 32'(xin), 'h123);
        check("lat_lvl_c2", 32'(level), 0);
        step;
        check("lat_en_c3", 32'(en), 0);
        check("lat_hold", 32'(xin), 'h123);
        ens = 0;
        repeat (10) begin step; if (en) ens++; end
        check("lat_no_extra", ens, 0);
        // spacing: samples 1..5 back to back
        for (int k = 0; k < 45; k++) begin
            exp_en = k >= 2 && (k - 2) % 8 == 0 && (k - 2) / 8 < 5;
            check("spc_en", 32'(en), 32'(exp_en));
            if (exp_en) check("spc_xin", 32'(xin), (k - 2) / 8 + 1);
            if (k == 5) check("spc_lvl", 32'(level), 4);
            s_valid = k < 5;
            s_data  = DW'(k + 1);
            step;
        end
        s_valid = 1'b0;
        // full / pointer wrap with 20 samples offered continuously
        sent = 0; rcv = 0; mlev = 0; acc_prev = 0; saw_full = 0;
        for (int t = 0; t < 400 && rcv < 20; t++) begin
            if (acc_prev != 0) mlev++;
            if (en) begin
                mlev--;
                if (q.size() > 0) check("wrap_xin", 32'(xin), 32'(q.pop_front()));
                else check("wrap_extra_en", 1, 0);
                rcv++;
            end
            check("wrap_lvl", 32'(level), mlev);
            check("wrap_ready", 32'(s_ready), 32'(mlev < DEPTH));
            if (level == LW'(DEPTH)) saw_full = 1;
            s_valid  = sent < 20;
            s_data   = DW'(12'h200 + sent);
            acc_prev = (s_valid && s_ready) ? 1 : 0;
            if (acc_prev != 0) begin q.push_back(s_data); sent++; end
            step;
        end
        s_valid = 1'b0;
        check("wrap_full_seen", saw_full, 1);
        check("wrap_sent", sent, 20);
        check("wrap_rcv", rcv, 20);
        // mid-run reset with level 4
        repeat (10) step;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1;
            s_data  = DW'(12'h50 + k);
            step;
        end
        s_valid = 1'b0;
        check("mrr_lvl_pre", 32'(level), 4);
        rstn = 1'b0;
        #1;
        check("mrr_ready", 32'(s_ready), 0);
        step;
        check("mrr_en", 32'(en), 0);
        check("mrr_xin", 32'(xin), 0);
        check("mrr_lvl", 32'(level), 0);
        rstn = 1'b1;
        ens = 0;
        repeat (20) begin step; if (en) ens++; end
        check("mrr_no_strobe", ens, 0);
        s_valid = 1'b1;
        s_data  = 12'h7ab;
        step;
        s_valid = 1'b0;
        step;
        check("mrr_new_en", 32'(en), 1);
        check("mrr_new_xin", 32'(xin), 'h7ab);
        repeat (12) step;
`ifdef FIR_FEED_FLUSH_EN
        // flush: 3 data strobes, then 16 zero strobes at SLOT spacing
        begin
            int data_n, zeros, last;
            data_n = 0; zeros = 0; last = -1;
            for (int k = 0; k < 200; k++) begin
                if (en) begin
                    if (data_n < 3) begin
                        check("fl_data", 32'(xin), 'h31 + data_n);
                        data_n++;
                    end else begin
                        check("fl_zero", 32'(xin), 0);
                        if (zeros > 0) check("fl_zspace", k - last, SLOT);
                        last = k;
                        zeros++;
                    end
                end
                if (k >= 4 && zeros < 16) begin
                    check("fl_busy", 32'(flush_busy), 1);
                    check("fl_ready", 32'(s_ready), 0);
                end
                s_valid = k < 3 || (k >= 4 && k < 60);
                s_data  = k < 3 ? DW'(12'h31 + k) : 12'hbad;
                flush   = k == 3;
                step;
            end
            s_valid = 1'b0;
            flush   = 1'b0;
            check("fl_data_n", data_n, 3);
            check("fl_zero_n", zeros, 16);
            check("fl_end_busy", 32'(flush_busy), 0);
            check("fl_end_ready", 32'(s_ready), 1);
        end
`else
        // flush without the feature: no effect at all
        ens = 0;
        for (int k = 0; k < 30; k++) begin
            flush = k == 0;
            check("nf_busy", 32'(flush_busy), 0);
            check("nf_ready", 32'(s_ready), 1);
            if (en) ens++;
            step;
        end
        flush = 1'b0;
        check("nf_no_strobe", ens, 0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/fir_serial_feeder.md
FIR_SERIAL_FEEDER -- requirements
Module: fir_serial_feeder

Interface
REQ-001 SHALL have parameter DW, default 12, meaning sample width, matching the serial FIR xin width.
REQ-002 SHALL have parameter DEPTH, default 8, meaning FIFO depth in samples; power of 2, range 2..64.
REQ-003 SHALL have parameter SLOT, default 8, meaning the minimum cycle spacing between en pulses, equal to the serial FIR's 8-cycle MAC schedule; range 2..255.
REQ-004 SHALL have port clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: the upstream sample is valid.
REQ-007 SHALL have port s_ready, output, 1 bit: the block accepts the sample.
REQ-008 SHALL have port s_data, input, DW bits: the upstream two's-complement sample.
REQ-009 SHALL have port flush, input, 1 bit: a single-cycle flush request.
REQ-010 SHALL have port en, output, 1 bit: a single-cycle sample strobe to the FIR.
REQ-011 SHALL have port xin, output, DW bits: the FIR sample, registered and held between strobes.
REQ-012 SHALL have port level, output, clog2(DEPTH)+1 bits: the FIFO occupancy.
REQ-013 SHALL have port flush_busy, output, 1 bit: a flush sequence is in progress.

Function
REQ-014 SHALL accept a sample in any cycle where s_valid and s_ready are both high, writing s_data into the FIFO at that edge.
REQ-015 SHALL drive s_ready = rstn, and level < DEPTH, and not flush_busy; there is no bypass when full.
REQ-016 SHALL use a gap counter: it loads SLOT-1 on each en, decrements to 0 and holds at 0.
REQ-017 SHALL set en for one cycle and load xin from the FIFO head, in state RUN, when the gap counter is 0 and level > 0.
REQ-018 SHALL give a latency from accept in cycle c (empty FIFO, gap counter 0) to en high in cycle c+2, with xin equal to that sample from cycle c+2.
REQ-019 SHALL space consecutive en pulses exactly SLOT cycles apart while the FIFO stays non-empty, and never fewer than SLOT cycles apart.
REQ-020 SHALL leave level unchanged on a simultaneous write and read, and keep level within 0..DEPTH at all times.
REQ-021 SHALL wrap the FIFO pointers modulo DEPTH, with no corruption across the wrap.
REQ-022 SHALL hold xin at its last value when en is low, and never present it as X.
REQ-023 SHALL implement the FSM states IDLE, RUN, DRAIN and ZFILL.
REQ-024 SHALL move from IDLE to RUN when level > 0, and from RUN to IDLE when level = 0 and the gap counter is 0.
REQ-025 SHALL treat a flush pulse in IDLE or RUN as follows when FIR_FEED_FLUSH_EN is defined: go to DRAIN, then from DRAIN to ZFILL once level = 0 and the last en's gap has elapsed.
REQ-026 SHALL, in ZFILL, issue exactly 16 en pulses with xin = 0 at SLOT spacing (the full 16-tap delay line), then return to IDLE.
REQ-027 SHALL set flush_busy = 1 in DRAIN and ZFILL.
REQ-028 SHALL ignore flush while flush_busy is 1.
REQ-029 SHALL reject s_valid in DRAIN and ZFILL via s_ready = 0.

Reset
REQ-030 SHALL, while rstn = 0 at a clock edge, clear en, xin, level, both pointers, the gap counter and the zero counter to 0, and set the FSM to IDLE.
REQ-031 SHALL hold s_ready and flush_busy at 0 during reset.
REQ-032 SHALL, on reset mid-operation, discard FIFO contents and any pending flush, with no en pulse in the cycle after rstn rises.

Configuration
REQ-033 SHALL, with macro FIR_FEED_FLUSH_EN defined, implement the DRAIN/ZFILL flush per REQ-025..029.
REQ-034 SHALL, without FIR_FEED_FLUSH_EN, ignore flush, tie flush_busy to 0 and remove the DRAIN and ZFILL states and the zero counter; all other behaviour is identical.

Verification
REQ-035 SHALL cover basic latency: after reset, one sample 0x123 accepted in cycle 10 -> en=1 in cycle 12 only, xin=0x123, level back to 0.
REQ-036 SHALL cover spacing: 5 back-to-back samples 1..5 -> en in cycles c+2, +8, +16, +24, +32 with xin 1..5 in order.
REQ-037 SHALL cover full/wrap: 20 continuous s_valid with SLOT=8 and DEPTH=8 -> s_ready drops at level=8, no sample lost or duplicated, order preserved across the pointer wrap.
REQ-038 SHALL cover flush (macro defined): 3 samples then flush -> 3 data strobes, then 16 strobes with xin=0 at 8-cycle spacing, flush_busy high throughout, s_ready=0, then IDLE.
REQ-039 SHALL cover mid-run reset: rstn low for 1 cycle with level=4 -> level=0, en=0, xin=0 the next cycle, and no strobe until a new accept.
REQ-040 SHALL cover flush without the macro: a flush pulse -> flush_busy stays 0, s_ready unaffected, no zero strobes.
